// File: rtl/i2s_rx_if.sv
// -----------------------------------------------------------------------------
// i2s_rx_if
//  Bundles the codec-side serial pins and the parallel sample outputs of the
//  I2S capture block.
//  Signals:
//   bclk        codec bit clock (async to the system clock)
//   lrclk       codec ADC LR clock (async); 0 = left, 1 = right
//   sdata       codec ADC serial data (async)
//   left_chan   last complete left sample, signed, BITSIZE bits
//   right_chan  last complete right sample, signed, BITSIZE bits
//   valid       1-clk pulse: new L/R pair on left_chan/right_chan
//   err         1-clk pulse: short word detected and discarded
//  Modports:
//   master  drives the serial pins, observes the samples (codec / bench side)
//   slave   receives the serial pins, drives the samples (i2s_rx side)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface i2s_rx_if #(
   parameter int BITSIZE = 16
);
   logic                      bclk;
   logic                      lrclk;
   logic                      sdata;
   logic signed [BITSIZE-1:0] left_chan;
   logic signed [BITSIZE-1:0] right_chan;
   logic                      valid;
   logic                      err;

   modport master (
      output bclk, lrclk, sdata,
      input  left_chan, right_chan, valid, err
   );

   modport slave (
      input  bclk, lrclk, sdata,
      output left_chan, right_chan, valid, err
   );
endinterface

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
//  Captures I2S stereo audio from the codec ADC and presents parallel signed
//  left/right samples. The serial pins are oversampled by the system clock,
//  which must run at least 8x the bit clock.
//  Ports:
//   clk   system clock, all logic on posedge
//   rst   asynchronous active-low reset
//   bus   i2s_rx_if.slave: bclk/lrclk/sdata in, left_chan/right_chan/valid/err out
//  Parameters:
//   BITSIZE  sample width per channel, MSB first, two's complement
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2s_rx #(
   parameter int BITSIZE = 16
) (
   input  logic   clk,
   input  logic   rst,
   i2s_rx_if.slave bus
);

   localparam int CNT_W = $clog2(BITSIZE + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITSIZE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      WAIT_LR = 2'd0,
      SHIFT   = 2'd1,
      DONE    = 2'd2
   } state_t;

   logic                      bclk_s1, bclk_s2, bclk_s3;
   logic                      lrclk_s1, lrclk_s2;
   logic                      sdata_s1, sdata_s2;
   logic                      lr_prev;
   state_t                    state;
   logic                      chan;
   logic [CNT_W-1:0]          bitcnt;
   logic signed [BITSIZE-1:0] shreg;
   logic signed [BITSIZE-1:0] left_shadow;
   logic                      left_ok;   // a left word committed since the last valid
   logic                      fresh;     // SHIFT just entered from WAIT_LR, nothing shifted yet

   logic bit_tick;
   logic lr_edge;

   assign bit_tick = bclk_s2 & ~bclk_s3;
   assign lr_edge  = lrclk_s2 ^ lr_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bclk_s1        <= 1'b0;
         bclk_s2        <= 1'b0;
         bclk_s3        <= 1'b0;
         lrclk_s1       <= 1'b0;
         lrclk_s2       <= 1'b0;
         sdata_s1       <= 1'b0;
         sdata_s2       <= 1'b0;
         lr_prev        <= 1'b0;
         state          <= WAIT_LR;
         chan           <= 1'b0;
         bitcnt         <= '0;
         shreg          <= '0;
         left_shadow    <= '0;
         left_ok        <= 1'b0;
         fresh          <= 1'b0;
         bus.left_chan  <= '0;
         bus.right_chan <= '0;
         bus.valid      <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         // stage: pin synchronisers and bclk edge-detect flop
         bclk_s1  <= bus.bclk;
         bclk_s2  <= bclk_s1;
         bclk_s3  <= bclk_s2;
         lrclk_s1 <= bus.lrclk;
         lrclk_s2 <= lrclk_s1;
         sdata_s1 <= bus.sdata;
         sdata_s2 <= sdata_s1;

         bus.valid <= 1'b0;
         bus.err   <= 1'b0;

         if (bit_tick) begin
            lr_prev <= lrclk_s2;
         end

         // stage: word assembly FSM
         case (state)
            WAIT_LR: begin
               if (bit_tick && lr_edge) begin
                  chan   <= lrclk_s2;
                  bitcnt <= '0;
                  fresh  <= 1'b1;
                  if (!lrclk_s2) begin
                     left_ok <= 1'b0;
                  end
                  state  <= SHIFT;
               end
            end

            SHIFT: begin
               // Commit runs on the clk after the LSB tick; the next tick is at
               // least 8 clk away, so no tick is lost here.
               if (bitcnt == CNT_FULL) begin
                  if (!chan) begin
                     left_shadow <= shreg;
                     left_ok     <= 1'b1;
                  end else if (left_ok) begin
                     bus.left_chan  <= left_shadow;
                     bus.right_chan <= shreg;
                     bus.valid      <= 1'b1;
                     left_ok        <= 1'b0;
                  end
                  state <= DONE;
               end else if (bit_tick) begin
                  if (lr_edge) begin
                     // Short word: discard. An edge right after WAIT_LR with
                     // nothing shifted is the normal start-up case, not an error.
                     bus.err <= ~fresh;
                     chan    <= lrclk_s2;
                     bitcnt  <= '0;
                     fresh   <= 1'b0;
                     if (!lrclk_s2) begin
                        left_ok <= 1'b0;
                     end
                  end else begin
                     shreg  <= {shreg[BITSIZE-2:0], sdata_s2};
                     bitcnt <= bitcnt + CNT_ONE;
                     fresh  <= 1'b0;
                  end
               end
            end

            DONE: begin
               // Padding bits are ignored; bitcnt stays saturated at BITSIZE.
               if (bit_tick && lr_edge) begin
                  chan   <= lrclk_s2;
                  bitcnt <= '0;
                  fresh  <= 1'b0;
                  if (!lrclk_s2) begin
                     left_ok <= 1'b0;
                  end
                  state  <= SHIFT;
               end
            end

            default: begin
               state <= WAIT_LR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx
//  Directed bench for i2s_rx. A small I2S transmitter model drives the codec
//  pins one BCLK slot at a time (data and LR change on the BCLK fall, the
//  receiver samples on the rise). Slot 0 of each channel is the LR-edge slot;
//  data bits MSB..LSB occupy slots 1..16, remaining slots are zero padding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2s_rx;

   localparam int BITSIZE = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   i2s_rx_if #(.BITSIZE(BITSIZE)) bus ();

   i2s_rx #(.BITSIZE(BITSIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_tests   = 0;
   int          n_fail    = 0;
   int          valid_cnt = 0;
   int          err_cnt   = 0;
   int          lat_cnt   = 0;
   int          lat_seen  = 0;
   bit          lat_arm   = 1'b0;
   logic [31:0] exp_l     = 32'h0;
   logic [31:0] exp_r     = 32'h0;
   bit          jit_en    = 1'b0;
   int          jit_idx   = 0;
   int          jit_tab [8] = '{-1, 1, 0, 1, -1, 0, -1, 1};
   int          v0, e0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One BCLK period starting at a negedge of clk; optionally arms the
   // latency counter at the BCLK rise.
   task automatic slot(input logic lr, input logic d, input bit mark);
      int lo;
      int hi;
      lo = 8;
      hi = 8;
      if (jit_en) begin
         lo = lo + jit_tab[jit_idx % 8];
         hi = hi - jit_tab[(jit_idx + 3) % 8];
         jit_idx++;
      end
      bus.bclk  = 1'b0;
      bus.lrclk = lr;
      bus.sdata = d;
      repeat (lo) @(negedge clk);
      bus.bclk = 1'b1;
      if (mark) begin
         lat_cnt = 0;
         lat_arm = 1'b1;
      end
      repeat (hi) @(negedge clk);
   endtask

   task automatic send_chan(input logic lr, input logic [15:0] word, input int nbits,
                            input int nslots, input bit mark);
      logic d;
      for (int k = 0; k < nslots; k++) begin
         d = 1'b0;
         if (k >= 1 && k <= nbits) d = word[nbits-k];
         slot(lr, d, mark && (k == nbits));
      end
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nslots,
                        input bit mark);
      exp_l = {16'h0, l};
      exp_r = {16'h0, r};
      send_chan(1'b0, l, 16, nslots, 1'b0);
      send_chan(1'b1, r, 16, nslots, mark);
   endtask

   // Counts latency in posedges from the armed BCLK rise.
   always @(posedge clk) begin
      if (lat_arm) lat_cnt++;
   end

   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin
         valid_cnt++;
         check("valid_left",  $unsigned(bus.left_chan),  exp_l);
         check("valid_right", $unsigned(bus.right_chan), exp_r);
         check("valid_err_overlap", bus.err, 1'b0);
         if (lat_arm) begin
            check("latency", lat_cnt, 4);
            lat_arm = 1'b0;
            lat_seen++;
         end
      end
      if (bus.err === 1'b1) err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      bus.bclk  = 1'b0;
      bus.lrclk = 1'b0;
      bus.sdata = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_left",  $unsigned(bus.left_chan),  0);
      check("rst_right", $unsigned(bus.right_chan), 0);
      check("rst_valid", bus.valid, 0);
      check("rst_err",   bus.err,   0);
      @(negedge clk);
      rst = 1'b1;

      // 32 BCLK per channel, preceded by a right-channel primer so the first
      // left word starts on a real LR edge.
      send_chan(1'b1, 16'h0000, 16, 32, 1'b0);
      repeat (3) frame(16'h8001, 16'h7FFE, 32, 1'b0);
      check("t1_valid_cnt", valid_cnt, 3);
      check("t1_err_cnt",   err_cnt,   0);
      check("t1_left",  $unsigned(bus.left_chan),  32'h8001);
      check("t1_right", $unsigned(bus.right_chan), 32'h7FFE);

      // Minimum framing: LR-edge slot plus 16 data bits, no padding.
      v0 = valid_cnt;
      repeat (4) frame(16'h1234, 16'hABCD, 17, 1'b0);
      check("t2_valid_cnt", valid_cnt - v0, 4);
      check("t2_err_cnt",   err_cnt,        0);
      check("t2_left",  $unsigned(bus.left_chan),  32'h1234);
      check("t2_right", $unsigned(bus.right_chan), 32'hABCD);

      // Reset held through the start of a right word, released mid-word.
      rst = 1'b0;
      send_chan(1'b1, 16'h5555, 16, 10, 1'b0);
      check("t3_rst_left",  $unsigned(bus.left_chan),  0);
      check("t3_rst_right", $unsigned(bus.right_chan), 0);
      rst = 1'b1;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_chan(1'b1, 16'h5A5A, 16, 22, 1'b0);
      exp_l = 32'h0F0F;
      exp_r = 32'hF0F0;
      send_chan(1'b0, 16'h0F0F, 16, 32, 1'b0);
      check("t3_no_early_valid", valid_cnt - v0, 0);
      check("t3_left_hold", $unsigned(bus.left_chan), 0);
      send_chan(1'b1, 16'hF0F0, 16, 32, 1'b0);
      check("t3_first_valid", valid_cnt - v0, 1);
      frame(16'h0F0F, 16'hF0F0, 32, 1'b0);
      check("t3_valid_cnt", valid_cnt - v0, 2);
      check("t3_err_cnt",   err_cnt - e0,   0);
      check("t3_left",  $unsigned(bus.left_chan),  32'h0F0F);
      check("t3_right", $unsigned(bus.right_chan), 32'hF0F0);

      // Left word cut to 10 bits by an early LR edge.
      v0 = valid_cnt;
      e0 = err_cnt;
      send_chan(1'b0, 16'hDEAD, 16, 11, 1'b0);
      send_chan(1'b1, 16'hBEEF, 16, 32, 1'b0);
      check("t4_err_pulse",  err_cnt - e0,   1);
      check("t4_no_valid",   valid_cnt - v0, 0);
      check("t4_left_hold",  $unsigned(bus.left_chan),  32'h0F0F);
      check("t4_right_hold", $unsigned(bus.right_chan), 32'hF0F0);
      frame(16'h1357, 16'h2468, 32, 1'b0);
      check("t4_recover_valid", valid_cnt - v0, 1);
      check("t4_err_total",     err_cnt - e0,   1);
      check("t4_left",  $unsigned(bus.left_chan),  32'h1357);
      check("t4_right", $unsigned(bus.right_chan), 32'h2468);

      // Back-to-back frames with latency measured from the right LSB BCLK rise,
      // first with a steady BCLK, then with its phase jittered by +-1 clk.
      v0 = valid_cnt;
      e0 = err_cnt;
      lat_seen = 0;
      repeat (2) frame(16'hCAFE, 16'h0135, 17, 1'b1);
      jit_en = 1'b1;
      repeat (2) frame(16'hCAFE, 16'h0135, 17, 1'b1);
      jit_en = 1'b0;
      check("t5_valid_cnt", valid_cnt - v0, 4);
      check("t5_lat_seen",  lat_seen,       4);
      check("t5_lat_pending", lat_arm,      0);
      check("t5_err_cnt",   err_cnt - e0,   0);
      check("t5_left",  $unsigned(bus.left_chan),  32'hCAFE);
      check("t5_right", $unsigned(bus.right_chan), 32'h0135);

      // Asynchronous reset in the middle of a left word.
      send_chan(1'b0, 16'h7777, 16, 8, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      check("t6_async_left",  $unsigned(bus.left_chan),  0);
      check("t6_async_right", $unsigned(bus.right_chan), 0);
      check("t6_async_valid", bus.valid, 0);
      check("t6_async_err",   bus.err,   0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      v0 = valid_cnt;
      e0 = err_cnt;
      send_chan(1'b0, 16'h7777, 16, 24, 1'b0);
      send_chan(1'b1, 16'h9999, 16, 32, 1'b0);
      check("t6_ignored_valid", valid_cnt - v0, 0);
      check("t6_ignored_err",   err_cnt - e0,   0);
      check("t6_left_zero",  $unsigned(bus.left_chan),  0);
      check("t6_right_zero", $unsigned(bus.right_chan), 0);
      frame(16'h4321, 16'h8765, 32, 1'b0);
      check("t6_valid_cnt", valid_cnt - v0, 1);
      check("t6_left",  $unsigned(bus.left_chan),  32'h4321);
      check("t6_right", $unsigned(bus.right_chan), 32'h8765);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
